// File: rtl/sr_ctrl_pkg.sv
// Shared op and state encodings for the SR flop-bank controller.
package sr_ctrl_pkg;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

endpackage

// File: rtl/sr_bank_controller_if.sv
// Requester-side request/response bundle of the SR bank controller.
// Master is the requester population; slave is the controller.
interface sr_bank_controller_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [IDXW*NREQ-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic                 rsp_q;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, rsp_valid, rsp_q, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, rsp_valid, rsp_q, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// Latency: grant is combinational; pointer moves on the cycle advance is high.
// Backpressure: none; grant simply stays low while nothing is requested.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    logic [PW-1:0] ptr;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found                       = 1'b1;
                grant[(int'(ptr) + i) % N]  = 1'b1;
                grant_idx                   = PW'((int'(ptr) + i) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/sr_bank_controller.sv
// Serialises READ/SET/CLEAR/TOGGLE ops from NREQ requesters onto an SR flop bank.
// Latency: accept t, drive t+1, settle t+2, checked response t+3; next accept >= t+4.
// Backpressure: req_ready is only offered in IDLE, one-hot to the round-robin winner.
module sr_bank_controller
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    localparam int IDXW = (NFF > 1) ? $clog2(NFF) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_bank_controller_if.slave   bus,
    output logic [NFF-1:0]        ff_s,
    output logic [NFF-1:0]        ff_r,
    input  logic [NFF-1:0]        ff_q,
    output logic                  busy
);
    localparam int OWW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic in_range(input logic [IDXW-1:0] i);
        return int'(i) < NFF;
    endfunction

    state_e            state, state_nxt;
    logic [NREQ-1:0]   grant;
    logic [OWW-1:0]    grant_idx;
    logic              accept;
    logic [1:0]        sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic              sel_ok, sel_q, sel_s, sel_r;
    logic [OWW-1:0]    own_r;
    logic [1:0]        op_r;
    logic [IDXW-1:0]   idx_r;
    logic              old_q_r, idx_ok_r, cur_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept  = (state == ST_IDLE) && rst && (|grant);
    assign sel_op  = bus.req_op[int'(grant_idx) * 2 +: 2];
    assign sel_idx = bus.req_idx[int'(grant_idx) * IDXW +: IDXW];
    assign sel_ok  = in_range(sel_idx);
    assign sel_q   = sel_ok ? ff_q[sel_idx] : 1'b0;
    // TOGGLE chooses its direction from q as sampled at accept, so s and r can never both fire.
    assign sel_s   = (sel_op == OP_SET)   || ((sel_op == OP_TOGGLE) && !sel_q);
    assign sel_r   = (sel_op == OP_CLEAR) || ((sel_op == OP_TOGGLE) &&  sel_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_r    <= '0;
            op_r     <= OP_READ;
            idx_r    <= '0;
            old_q_r  <= 1'b0;
            idx_ok_r <= 1'b0;
        end else if (accept) begin
            own_r    <= grant_idx;
            op_r     <= sel_op;
            idx_r    <= sel_idx;
            old_q_r  <= sel_q;
            idx_ok_r <= sel_ok;
        end
    end

    // The drive pulse is registered so it lives for exactly the DRIVE cycle and clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_s <= '0;
            ff_r <= '0;
        end else begin
            ff_s <= (accept && sel_ok && sel_s) ? (NFF'(1) << sel_idx) : '0;
            ff_r <= (accept && sel_ok && sel_r) ? (NFF'(1) << sel_idx) : '0;
        end
    end

    assign cur_q = idx_ok_r ? ff_q[idx_r] : 1'b0;

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_q     = 1'b0;
        bus.rsp_err   = 1'b0;
        busy          = (state != ST_IDLE);
        if (state == ST_IDLE && rst) begin
            bus.req_ready = grant;
        end
        if (state == ST_CHECK) begin
            bus.rsp_valid[own_r] = 1'b1;
            bus.rsp_q            = cur_q;
            if (!idx_ok_r) begin
                bus.rsp_err = 1'b1;
            end else begin
                case (op_r)
                    OP_SET:    bus.rsp_err = !cur_q;
                    OP_CLEAR:  bus.rsp_err = cur_q;
                    OP_TOGGLE: bus.rsp_err = (cur_q == old_q_r);
                    default:   bus.rsp_err = 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sr_bank_controller.sv
// Directed bench for sr_bank_controller with a behavioural SR flop bank model.
module tb_sr_bank_controller;
    import sr_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ff_s, ff_r;
    logic [7:0] q_model = 8'h00;
    logic [7:0] stuck   = 8'h00;
    logic       busy;
    int         n_chk  = 0;
    int         n_fail = 0;

    sr_bank_controller_if #(.NREQ(4), .IDXW(3)) bus ();

    sr_bank_controller #(.NREQ(4), .NFF(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .ff_s (ff_s),
        .ff_r (ff_r),
        .ff_q (q_model),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Gated SR flops; stuck bits model a broken cell that never sets.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (stuck[i])     q_model[i] <= 1'b0;
            else if (ff_s[i]) q_model[i] <= 1'b1;
            else if (ff_r[i]) q_model[i] <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("s_and_r_disjoint", 32'(ff_s & ff_r), 32'h0);
        chk("at_most_one_drive", 32'($countones(ff_s | ff_r) <= 1), 32'h1);
    end

    typedef struct {
        int         rq;
        logic [1:0] op;
        logic [2:0] idx;
        logic       stuck5;
        logic [7:0] es;
        logic [7:0] er;
        logic       eq;
        logic       ee;
    } vec_t;

    vec_t vecs[12];

    task automatic do_op(input int k);
        logic [3:0] one;
        one = 4'(1) << vecs[k].rq;
        stuck[5]      = vecs[k].stuck5;
        bus.req_valid = one;
        bus.req_op    = '0;
        bus.req_idx   = '0;
        bus.req_op[vecs[k].rq * 2 +: 2]  = vecs[k].op;
        bus.req_idx[vecs[k].rq * 3 +: 3] = vecs[k].idx;
        #1;
        chk($sformatf("v%0d_ready", k), 32'(bus.req_ready), 32'(one));
        @(negedge clk);
        bus.req_valid = '0;
        chk($sformatf("v%0d_drive_s", k), 32'(ff_s), 32'(vecs[k].es));
        chk($sformatf("v%0d_drive_r", k), 32'(ff_r), 32'(vecs[k].er));
        chk($sformatf("v%0d_busy", k), 32'(busy), 32'h1);
        chk($sformatf("v%0d_ready_busy", k), 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_settle_sr", k), 32'(ff_s | ff_r), 32'h0);
        chk($sformatf("v%0d_settle_rsp", k), 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(one));
        chk($sformatf("v%0d_rsp_q", k), 32'(bus.rsp_q), 32'(vecs[k].eq));
        chk($sformatf("v%0d_rsp_err", k), 32'(bus.rsp_err), 32'(vecs[k].ee));
        @(negedge clk);
        chk($sformatf("v%0d_idle", k), 32'(busy), 32'h0);
        chk($sformatf("v%0d_rsp_drop", k), 32'(bus.rsp_valid), 32'h0);
    endtask

    initial begin
        logic [3:0] grants[5];
        int         gcyc[5];
        logic [3:0] rsps[4];
        int         ng, nr;

        //              rq  op         idx  stk  s      r      q     err
        vecs[0]  = '{0, OP_SET,    3'd3, 0, 8'h08, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1, OP_TOGGLE, 3'd3, 0, 8'h00, 8'h08, 1'b0, 1'b0};
        vecs[2]  = '{2, OP_TOGGLE, 3'd3, 0, 8'h08, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{3, OP_READ,   3'd3, 0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{0, OP_CLEAR,  3'd3, 0, 8'h00, 8'h08, 1'b0, 1'b0};
        vecs[5]  = '{1, OP_SET,    3'd0, 0, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{2, OP_SET,    3'd7, 0, 8'h80, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{3, OP_CLEAR,  3'd7, 0, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[8]  = '{0, OP_CLEAR,  3'd2, 0, 8'h00, 8'h04, 1'b0, 1'b0};
        vecs[9]  = '{1, OP_READ,   3'd0, 0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{2, OP_SET,    3'd5, 1, 8'h20, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{3, OP_READ,   3'd5, 1, 8'h00, 8'h00, 1'b0, 1'b0};

        // Reset held with every requester asking.
        bus.req_valid = 4'hF;
        bus.req_op    = {4{OP_SET}};
        bus.req_idx   = 12'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_sr", 32'(ff_s | ff_r), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        bus.req_valid = '0;
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) do_op(k);
        stuck = 8'h00;

        // Reset in the middle of DRIVE: pulse must vanish at once, op is dropped.
        bus.req_valid = 4'b0100;
        bus.req_op    = {2'b00, OP_SET, 2'b00, 2'b00};
        bus.req_idx   = {3'd0, 3'd1, 3'd0, 3'd0};
        @(negedge clk);
        bus.req_valid = '0;
        chk("mid_drive_s", 32'(ff_s), 32'h02);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_s_clear", 32'(ff_s), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_rsp", 32'(bus.rsp_valid), 32'h0);
            chk("post_rst_busy", 32'(busy), 32'h0);
        end

        // Round-robin with all requesters continuously valid; first grant proves pointer reset.
        bus.req_valid = 4'hF;
        bus.req_op    = '0;
        bus.req_idx   = '0;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (bus.req_ready != 0) begin
                grants[ng] = bus.req_ready;
                gcyc[ng]   = c;
                ng++;
            end
            if (bus.rsp_valid != 0 && nr < 4) begin
                rsps[nr] = bus.rsp_valid;
                nr++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        chk("rr_grant_count", 32'(ng), 32'd5);
        chk("rr_rsp_count", 32'(nr), 32'd4);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) begin
                chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(4'(1) << (i % 4)));
                if (i > 0) chk($sformatf("rr_space%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < nr) chk($sformatf("rr_rsp%0d", i), 32'(rsps[i]), 32'(4'(1) << i));
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
